// File: rtl/fetch_execute_controller.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Owns PC/IR/MAR/MBR/AC, drives synchronous-read memory and an external combinational ALU.
module fetch_execute_controller #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [11:0] pc,
  output logic [15:0] ac,
  output logic [15:0] ir,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StIrLoad, StDecode, StOperand, StExec, StStore, StHalt
  } state_e;

  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpAdd   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h4;
  localparam logic [3:0] OpAnd   = 4'h5;
  localparam logic [3:0] OpOr    = 4'h6;
  localparam logic [3:0] OpHalt  = 4'h7;
  localparam logic [3:0] OpSkip  = 4'h8;
  localparam logic [3:0] OpJump  = 4'h9;
  localparam logic [3:0] OpClear = 4'hA;
  localparam logic [3:0] OpXor   = 4'hB;

  state_e      state_q, state_d;
  logic [11:0] pc_q, mar_q;
  logic [15:0] ir_q, mbr_q, ac_q;

  logic [3:0]  opcode;
  logic [11:0] addr_x;
  logic        is_mem_read;
  logic        skip_taken;

  assign opcode = ir_q[15:12];
  assign addr_x = ir_q[11:0];

  always_comb begin
    is_mem_read = 1'b0;
    case (opcode)
      OpLoad, OpAdd, OpSub, OpAnd, OpOr, OpXor: is_mem_read = 1'b1;
      default:                                  is_mem_read = 1'b0;
    endcase
  end

  always_comb begin
    skip_taken = 1'b0;
    unique case (ir_q[11:10])
      2'b00: skip_taken = ac_q[15];
      2'b01: skip_taken = (ac_q == 16'h0000);
      2'b10: skip_taken = !ac_q[15] && (ac_q != 16'h0000);
      2'b11: skip_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (run) state_d = StFetch;
      StFetch:   state_d = StIrLoad;
      StIrLoad:  state_d = StDecode;
      StDecode: begin
        if (is_mem_read)            state_d = StOperand;
        else if (opcode == OpStore) state_d = StStore;
        else if (opcode == OpHalt)  state_d = StHalt;
        else                        state_d = StFetch;
      end
      StOperand: state_d = StExec;
      StExec:    state_d = StFetch;
      StStore:   state_d = StFetch;
      StHalt:    state_d = StHalt;
    endcase
  end

  // Outputs are purely a function of state so reset kills mem_we immediately
  always_comb begin
    mem_addr   = 16'h0000;
    mem_we     = 1'b0;
    alu_op     = 4'b0000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      StIdle, StIrLoad, StOperand: ;
      StFetch:  mem_addr = {4'b0000, pc_q};
      StDecode: begin
        if (is_mem_read) mem_addr = {4'b0000, addr_x};
        instr_done = !is_mem_read && (opcode != OpStore);
        illegal    = (opcode[3:2] == 2'b11);
      end
      StExec: begin
        instr_done = 1'b1;
        case (opcode)
          OpSub:   alu_op = 4'b0001;
          OpAnd:   alu_op = 4'b1000;
          OpOr:    alu_op = 4'b1001;
          OpXor:   alu_op = 4'b1010;
          default: alu_op = 4'b0000;
        endcase
      end
      StStore: begin
        mem_addr   = {4'b0000, mar_q};
        mem_we     = 1'b1;
        instr_done = 1'b1;
      end
      StHalt:   halted = 1'b1;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= 16'h0000;
      mar_q <= 12'h000;
      mbr_q <= 16'h0000;
      ac_q  <= 16'h0000;
    end else begin
      unique case (state_q)
        StIrLoad: begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + 12'd1;
        end
        StDecode: begin
          if (is_mem_read || opcode == OpStore) mar_q <= addr_x;
          if (opcode == OpJump)                 pc_q  <= addr_x;
          if (opcode == OpSkip && skip_taken)   pc_q  <= pc_q + 12'd1;
          if (opcode == OpClear)                ac_q  <= 16'h0000;
        end
        StOperand: mbr_q <= mem_rdata;
        StExec:    ac_q  <= (opcode == OpLoad) ? mbr_q : alu_result;
        StIdle, StFetch, StStore, StHalt: ;
      endcase
    end
  end

  assign mem_wdata = ac_q;
  assign alu_a     = ac_q;
  assign alu_b     = mbr_q;
  assign pc        = pc_q;
  assign ac        = ac_q;
  assign ir        = ir_q;

endmodule

// File: tb/tb_fetch_execute_controller.sv
// Bench for fetch_execute_controller: memory + ALU environment, and an instruction-level
// reference model that predicts PC/AC/memory/cycle counts for directed and random programs.
module tb_fetch_execute_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [11:0] pc;
  logic [15:0] ac, ir;
  logic        halted, instr_done, illegal;

  fetch_execute_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .halted     (halted),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  // Environment: 4K x 16 synchronous-read memory and combinational ALU
  logic [15:0] mem     [4096];
  logic [15:0] image   [4096];
  logic [15:0] ref_mem [4096];
  logic        load = 1'b0;

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= image[i];
    end else if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[11:0]];
  end

  always_comb begin
    alu_result = 16'hDEAD;
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'hDEAD;
    endcase
  end

  int tests = 0;
  int fails = 0;
  int cyc_total;
  int n_done;

  // Reference machine state
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  bit          m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 4096; i++) image[i] = 16'h0000;
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc, 12'h000);
    check("rst_ac", ac, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_done", instr_done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
  endtask

  // Reset, load the image, release reset with run high; returns #1 after entering FETCH
  task automatic start_program();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clock);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = image[i];
    m_pc = 12'h000;
    m_ac = 16'h0000;
    m_halt = 1'b0;
    cyc_total = 0;
    n_done = 0;
    run = 1'b1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Run one instruction on the DUT and the model, then compare architectural state
  task automatic step(output bit ok);
    logic [15:0] instr;
    logic [3:0]  op;
    logic [11:0] x;
    int          n, nill, nwe, exp_cyc;
    bit          cond;
    instr = ref_mem[m_pc];
    op = instr[15:12];
    x = instr[11:0];
    n = 0;
    nill = 0;
    nwe = 0;
    ok = 1'b1;
    do begin
      @(negedge clock);
      n++;
      nill += int'(illegal);
      nwe += int'(mem_we);
    end while (!instr_done && n < 12);
    check("instr_done_seen", instr_done, 1'b1);
    if (!instr_done) begin
      ok = 1'b0;
      return;
    end
    n_done++;
    cyc_total += n;

    m_pc = m_pc + 12'd1;
    cond = 1'b0;
    case (op)
      4'h1: m_ac = ref_mem[x];
      4'h2: ref_mem[x] = m_ac;
      4'h3: m_ac = m_ac + ref_mem[x];
      4'h4: m_ac = m_ac - ref_mem[x];
      4'h5: m_ac = m_ac & ref_mem[x];
      4'h6: m_ac = m_ac | ref_mem[x];
      4'hB: m_ac = m_ac ^ ref_mem[x];
      4'h7: m_halt = 1'b1;
      4'h8: begin
        case (x[11:10])
          2'b00:   cond = $signed(m_ac) < 16'sd0;
          2'b01:   cond = (m_ac == 16'h0000);
          2'b10:   cond = $signed(m_ac) > 16'sd0;
          default: cond = 1'b0;
        endcase
        if (cond) m_pc = m_pc + 12'd1;
      end
      4'h9: m_pc = x;
      4'hA: m_ac = 16'h0000;
      default: ;
    endcase
    if (op == 4'h1 || op == 4'h3 || op == 4'h4 || op == 4'h5 || op == 4'h6 || op == 4'hB)
      exp_cyc = 5;
    else if (op == 4'h2)
      exp_cyc = 4;
    else
      exp_cyc = 3;

    check("cycles", n, exp_cyc);
    check("illegal_pulses", nill, (op >= 4'hC) ? 1 : 0);
    check("we_cycles", nwe, (op == 4'h2) ? 1 : 0);
    @(posedge clock);
    #1;
    check("ir", ir, instr);
    check("pc", pc, m_pc);
    check("ac", ac, m_ac);
    check("halted", halted, m_halt);
    if (op == 4'h2) check("store_data", mem[x], ref_mem[x]);
  endtask

  task automatic run_program(input int max_instr);
    bit ok;
    int mism;
    logic [11:0] pc_at_halt;
    start_program();
    for (int i = 0; i < max_instr; i++) begin
      step(ok);
      if (!ok || m_halt) break;
    end
    if (m_halt) begin
      pc_at_halt = m_pc;
      repeat (4) @(negedge clock);
      check("halt_stays", halted, 1'b1);
      check("halt_pc", pc, pc_at_halt);
    end
    mism = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image", mism, 0);
  endtask

  initial begin
    bit ok;

    // LOAD/ADD/STORE/HALT program
    clear_image();
    image[0] = 16'h1005; image[1] = 16'h3006; image[2] = 16'h2007; image[3] = 16'h7000;
    image[5] = 16'h0003; image[6] = 16'h0004;
    run_program(10);
    check("prog_m7", mem[7], 16'h0007);
    check("prog_ac", ac, 16'h0007);
    check("prog_pc", pc, 12'h004);
    check("prog_halted", halted, 1'b1);
    check("prog_dones", n_done, 4);
    check("prog_cycles", cyc_total, 17);

    // SKIPCOND: zero, negative, positive conditions
    clear_image();
    image[0] = 16'hA000; image[1] = 16'h8400; image[2] = 16'h7000; image[3] = 16'h8000;
    image[4] = 16'h1010; image[5] = 16'h8000; image[6] = 16'h7000; image[7] = 16'h8800;
    image[8] = 16'h7000; image[16] = 16'h8000;
    run_program(20);
    check("skip_pc", pc, 12'h009);
    check("skip_ac", ac, 16'h8000);

    // JUMP to top of memory and wrap
    clear_image();
    image[0] = 16'h9FFF;
    image[12'hFFF] = 16'h0000;
    run_program(2);
    check("wrap_pc", pc, 12'h000);

    // Illegal opcode behaves as NOP
    clear_image();
    image[0] = 16'h1005; image[1] = 16'hC123; image[2] = 16'h7000; image[5] = 16'h0055;
    run_program(10);
    check("illegal_ac", ac, 16'h0055);
    check("illegal_pc", pc, 12'h003);

    // SUB borrow, then AND/OR/XOR
    clear_image();
    image[0] = 16'hA000; image[1] = 16'h4010; image[2] = 16'h5011; image[3] = 16'h6011;
    image[4] = 16'hB011; image[5] = 16'h7000;
    image[16] = 16'h0001; image[17] = 16'h0F0F;
    run_program(10);
    check("alu_final_ac", ac, 16'h0000);

    // Reset asserted in the middle of the STORE cycle
    clear_image();
    image[0] = 16'h1005; image[1] = 16'h2007; image[5] = 16'h1234;
    start_program();
    step(ok);
    repeat (3) @(posedge clock);
    #1;
    check("store_we_high", mem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_we_drop", mem_we, 1'b0);
    @(posedge clock);
    #1;
    check("rst_no_write", mem[7], 16'h0000);
    check_reset_values();
    run = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("idle_pc", pc, 12'h000);
    check("idle_addr", mem_addr, 16'h0000);
    check("idle_done", instr_done, 1'b0);

    // Random programs over fully random memory
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 4096; i++) image[i] = 16'($urandom);
      run_program(60);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
